axi_write_channel_slave: RTL and testbench
==========================================

Name: axi_write_channel_slave

Overview:
AXI write-side slave endpoint covering the AW, W and B channels. It accepts one write burst at a time: it captures the address request, accepts data beats until WLAST, then returns a write response. For each accepted beat it presents the beat address and data on flat output registers (AWADDROUT / WDATAOUT) for downstream logic, such as the I2C command path of the bridge.

Parameters:
ADDR_WIDTH, 32, AWADDR/AWADDROUT width
SIZE, 3, AWSIZE width
BURST_SIZE, 2, AWBURST width
WDATA_WIDTH, 32, WDATA/WDATAOUT width (bytes per bus = WDATA_WIDTH/8)
RESPONSE_WIDTH, 2, BRESP width

Ports:
ACLK  in  1  clock, all state on rising edge
ARESETn  in  1  reset, asynchronous, active-high
AWVALID  in  1  write request valid
AWREADY  out  1  write request ready
AWADDR  in  ADDR_WIDTH  burst start address
AWSIZE  in  SIZE  bytes per beat = 2**AWSIZE
AWBURST  in  BURST_SIZE  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWADDROUT  out  ADDR_WIDTH  address of beat currently on WDATAOUT
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  WDATA_WIDTH  write data
WLAST  in  1  last beat of burst
WDATAOUT  out  WDATA_WIDTH  last accepted beat data
BVALID  out  1  response valid
BREADY  in  1  response ready
BRESP  out  RESPONSE_WIDTH  00 OKAY, 10 SLVERR

Behaviour:
- Interface: one clock (ACLK); reset ARESETn is asynchronous and active-high.
- Reset state: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, AWADDROUT=0, WDATAOUT=0, FSM=IDLE, internal address and error flag 0.
- All outputs are registered.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY rises one cycle after reset is released and stays high.
  - A handshake occurs at an edge with AWVALID & AWREADY. At that edge:
    - AWADDROUT <= AWADDR.
    - Latch AWSIZE, AWBURST and next-address register = AWADDR.
    - Compute error flag.
    - AWREADY <= 0, WREADY <= 1, go to DATA.
- Error flag is set when AWBURST is 10 or 11 (WRAP is unsupported because there is no AWLEN), or when 2**AWSIZE > WDATA_WIDTH/8.
- DATA: each edge with WVALID & WREADY is one beat.
  - If no error: WDATAOUT <= WDATA, and AWADDROUT <= the current beat address.
  - If error: WDATAOUT and AWADDROUT hold their values, but the beat is still consumed.
  - FIXED: beat address stays at the start address.
  - INCR: next = (addr & ~(2**AWSIZE-1)) + 2**AWSIZE, modulo 2**ADDR_WIDTH.
  - First beat uses the unaligned start address; later beats are size-aligned.
- WLAST beat: at that edge, WREADY <= 0, BVALID <= 1, BRESP <= (error ? 10 : 00), go to RESP.
- Burst length is unbounded and is terminated only by WLAST.
- RESP:
  - BVALID and BRESP hold until an edge with BREADY=1.
  - At that edge: BVALID <= 0, BRESP <= 00, AWREADY <= 1, go to IDLE.
- Back-to-back bursts: minimum 1 idle cycle between the B handshake and the next AW handshake.
- WVALID outside DATA is ignored (WREADY=0); no data buffering.
- AWVALID outside IDLE is ignored (AWREADY=0).
- BREADY already high when BVALID rises: BVALID lasts exactly one cycle.
- Reset mid-burst: outputs return to reset values immediately; the burst is dropped with no response.
- Only one outstanding transaction.

Optional Feature:
- Macro: AXI_WR_4KB_CHECK_EN.
- When defined, an INCR burst whose beat address crosses a 4 KB boundary sets the error flag at that beat. That beat and all remaining beats are consumed without updating WDATAOUT/AWADDROUT, and BRESP=10.
- When undefined, no boundary check is made; addresses simply increment and wrap at 2**ADDR_WIDTH.

Test Plan:
- Reset then idle: ARESETn high for 50 ns, then low → all outputs 0; AWREADY=1 one cycle after release; BVALID stays 0 with no stimulus.
- FIXED write: AWVALID=1, AWADDR=32'hABAB, AWBURST=00, AWSIZE=2; 3 beats 11,22,33 with WLAST on 3rd → AWADDROUT=ABAB on every beat; WDATAOUT ends 33; BVALID=1, BRESP=00 the cycle after the last beat.
- INCR write: AWADDR=32'h1002, AWSIZE=2, AWBURST=01, 3 beats → AWADDROUT sequence 1002, 1004, 1008; BRESP=00.
- Error: AWBURST=11 (also AWSIZE=3 with WDATA_WIDTH=32), 2 beats → WDATAOUT unchanged; BRESP=10.
- Backpressure: BREADY=0 for 5 cycles → BVALID/BRESP held stable; AWREADY stays 0; WVALID pulses ignored. BREADY=1 → BVALID drops, AWREADY rises next cycle.
- Reset mid-burst: assert ARESETn after 1 of 3 beats → WREADY/AWADDROUT/WDATAOUT go to 0 asynchronously; no BVALID; the next burst completes normally.

Source files
------------

// File: rtl/axi_write_channel_slave.sv
// AXI write-side slave (AW/W/B): one burst at a time, beat address/data exposed on flat registers.
// Optional AXI_WR_4KB_CHECK_EN: INCR beats that leave the start 4 KB page are errored.
module axi_write_channel_slave #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SIZE           = 3,
  parameter int unsigned BURST_SIZE     = 2,
  parameter int unsigned WDATA_WIDTH    = 32,
  parameter int unsigned RESPONSE_WIDTH = 2
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  // AW channel
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [SIZE-1:0]           AWSIZE,
  input  logic [BURST_SIZE-1:0]     AWBURST,
  output logic [ADDR_WIDTH-1:0]     AWADDROUT,
  // W channel
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic [WDATA_WIDTH-1:0]    WDATA,
  input  logic                      WLAST,
  output logic [WDATA_WIDTH-1:0]    WDATAOUT,
  // B channel
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [RESPONSE_WIDTH-1:0] BRESP
);

  localparam int unsigned MaxSizeLog2 = $clog2(WDATA_WIDTH / 8);

  localparam logic [BURST_SIZE-1:0]     BurstFixed = BURST_SIZE'(0);
  localparam logic [BURST_SIZE-1:0]     BurstIncr  = BURST_SIZE'(1);
  localparam logic [RESPONSE_WIDTH-1:0] RespOkay   = RESPONSE_WIDTH'(0);
  localparam logic [RESPONSE_WIDTH-1:0] RespSlverr = RESPONSE_WIDTH'(2);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StResp
  } state_e;

  state_e                    state_q, state_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [RESPONSE_WIDTH-1:0] bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0]     awaddrout_q, awaddrout_d;
  logic [WDATA_WIDTH-1:0]    wdataout_q, wdataout_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [SIZE-1:0]           size_q, size_d;
  logic [BURST_SIZE-1:0]     burst_q, burst_d;
  logic                      err_q, err_d;

  logic                      aw_err;
  logic                      beat_err;
  logic [ADDR_WIDTH-1:0]     beat_bytes;
  logic [ADDR_WIDTH-1:0]     next_incr;

  // WRAP and reserved encodings are rejected because there is no AWLEN to size a wrap window.
  assign aw_err = ((AWBURST != BurstFixed) && (AWBURST != BurstIncr)) ||
                  (32'(AWSIZE) > MaxSizeLog2);

  assign beat_bytes = ADDR_WIDTH'(1) << size_q;
  assign next_incr  = (addr_q & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;

`ifdef AXI_WR_4KB_CHECK_EN
  logic [ADDR_WIDTH-13:0] page_q, page_d;

  // Once a beat leaves the start page the error sticks for the rest of the burst.
  assign beat_err = err_q ||
                    ((burst_q == BurstIncr) && (addr_q[ADDR_WIDTH-1:12] != page_q));

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      page_q <= '0;
    end else begin
      page_q <= page_d;
    end
  end

  always_comb begin
    page_d = page_q;
    if ((state_q == StIdle) && awready_q && AWVALID) begin
      page_d = AWADDR[ADDR_WIDTH-1:12];
    end
  end
`else
  assign beat_err = err_q;
`endif

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state_q     <= StIdle;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RespOkay;
      awaddrout_q <= '0;
      wdataout_q  <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      awaddrout_q <= awaddrout_d;
      wdataout_q  <= wdataout_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    awaddrout_d = awaddrout_q;
    wdataout_d  = wdataout_q;
    addr_d      = addr_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (!awready_q) begin
          awready_d = 1'b1;
        end else if (AWVALID) begin
          awaddrout_d = AWADDR;
          addr_d      = AWADDR;
          size_d      = AWSIZE;
          burst_d     = AWBURST;
          err_d       = aw_err;
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          state_d     = StData;
        end
      end

      StData: begin
        if (WVALID && wready_q) begin
          // Errored beats are consumed but leave the output registers untouched.
          if (!beat_err) begin
            wdataout_d  = WDATA;
            awaddrout_d = addr_q;
          end
          if (burst_q == BurstIncr) begin
            addr_d = next_incr;
          end
          err_d = beat_err;
          if (WLAST) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = beat_err ? RespSlverr : RespOkay;
            state_d  = StResp;
          end
        end
      end

      StResp: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RespOkay;
          awready_d = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign AWADDROUT = awaddrout_q;
  assign WDATAOUT  = wdataout_q;

endmodule

// File: tb/tb_axi_write_channel_slave.sv
// Bench for axi_write_channel_slave: transaction-level model checked every negedge,
// plus directed bursts with hand-computed literal pins.
module tb_axi_write_channel_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic [31:0] AWADDROUT;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA = '0;
  logic        WLAST = 1'b0;
  logic [31:0] WDATAOUT;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [1:0]  BRESP;

  int n_checks = 0;
  int n_fail   = 0;

  axi_write_channel_slave #(
    .ADDR_WIDTH    (32),
    .SIZE          (3),
    .BURST_SIZE    (2),
    .WDATA_WIDTH   (32),
    .RESPONSE_WIDTH(2)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWADDR   (AWADDR),
    .AWSIZE   (AWSIZE),
    .AWBURST  (AWBURST),
    .AWADDROUT(AWADDROUT),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .WLAST    (WLAST),
    .WDATAOUT (WDATAOUT),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Transaction-level model ----------------
  logic        exp_awready, exp_wready, exp_bvalid;
  logic [1:0]  exp_bresp;
  logic [31:0] exp_awaddrout, exp_wdataout;
  logic [31:0] m_start;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic        m_err;
  int          m_beat;

  // Address of the k-th beat of a burst, computed directly rather than by accumulation.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [1:0] burst, input int k);
    logic [31:0] bytes;
    bytes = 32'd1 << size;
    if (burst == 2'b00 || k == 0) return start;
    return (start & ~(bytes - 32'd1)) + bytes * 32'(k);
  endfunction

  function automatic logic request_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b10) || (burst == 2'b11) || ((32'd1 << size) > 32'd4);
  endfunction

  function automatic logic page_cross(input int k);
`ifdef AXI_WR_4KB_CHECK_EN
    logic [31:0] a;
    a = beat_addr(m_start, m_size, m_burst, k);
    return (m_burst == 2'b01) && (a[31:12] != m_start[31:12]);
`else
    return (k < 0);
`endif
  endfunction

  always @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      exp_awready   <= 1'b0;
      exp_wready    <= 1'b0;
      exp_bvalid    <= 1'b0;
      exp_bresp     <= 2'b00;
      exp_awaddrout <= '0;
      exp_wdataout  <= '0;
      m_start       <= '0;
      m_size        <= '0;
      m_burst       <= '0;
      m_err         <= 1'b0;
      m_beat        <= 0;
    end else if (exp_wready) begin
      if (WVALID) begin
        if (!(m_err || page_cross(m_beat))) begin
          exp_wdataout  <= WDATA;
          exp_awaddrout <= beat_addr(m_start, m_size, m_burst, m_beat);
        end
        m_err  <= m_err || page_cross(m_beat);
        m_beat <= m_beat + 1;
        if (WLAST) begin
          exp_wready <= 1'b0;
          exp_bvalid <= 1'b1;
          exp_bresp  <= (m_err || page_cross(m_beat)) ? 2'b10 : 2'b00;
        end
      end
    end else if (exp_bvalid) begin
      if (BREADY) begin
        exp_bvalid  <= 1'b0;
        exp_bresp   <= 2'b00;
        exp_awready <= 1'b1;
      end
    end else if (!exp_awready) begin
      exp_awready <= 1'b1;
    end else if (AWVALID) begin
      m_start       <= AWADDR;
      m_size        <= AWSIZE;
      m_burst       <= AWBURST;
      m_err         <= request_err(AWBURST, AWSIZE);
      m_beat        <= 0;
      exp_awaddrout <= AWADDR;
      exp_awready   <= 1'b0;
      exp_wready    <= 1'b1;
    end
  end

  always @(negedge ACLK) begin
    check("awready", AWREADY, exp_awready);
    check("wready", WREADY, exp_wready);
    check("bvalid", BVALID, exp_bvalid);
    check("bresp", BRESP, exp_bresp);
    check("awaddrout", AWADDROUT, exp_awaddrout);
    check("wdataout", WDATAOUT, exp_wdataout);
  end

  // DUT and model both pinned to a hand-computed value.
  task automatic pin(input string name, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                     input logic [63:0] lit);
    check({name, "_dut"}, dut_v, lit);
    check({name, "_model"}, mdl_v, lit);
  endtask

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    bit ok;
    ok      = 1'b0;
    AWADDR  = a;
    AWSIZE  = s;
    AWBURST = b;
    AWVALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (AWREADY) ok = 1'b1;
      else step();
    end
    check("aw_handshake_timeout", {63'd0, ok}, 64'd1);
    step();
    AWVALID = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] d, input logic last);
    bit ok;
    ok     = 1'b0;
    WDATA  = d;
    WLAST  = last;
    WVALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (WREADY) ok = 1'b1;
      else step();
    end
    check("w_handshake_timeout", {63'd0, ok}, 64'd1);
    step();
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic do_b();
    bit ok;
    ok     = 1'b0;
    BREADY = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (BVALID) ok = 1'b1;
      else step();
    end
    check("b_handshake_timeout", {63'd0, ok}, 64'd1);
    step();
    BREADY = 1'b0;
  endtask

  initial begin
    // Reset then idle
    #52;
    pin("rst_awready", AWREADY, exp_awready, 0);
    pin("rst_awaddrout", AWADDROUT, exp_awaddrout, 0);
    ARESETn = 1'b0;
    step();
    pin("awready_after_rst", AWREADY, exp_awready, 1);
    repeat (3) step();
    pin("idle_bvalid", BVALID, exp_bvalid, 0);

    // FIXED burst
    do_aw(32'hABAB, 3'd2, 2'b00);
    do_beat(32'h11, 1'b0);
    pin("fixed_addr1", AWADDROUT, exp_awaddrout, 32'hABAB);
    do_beat(32'h22, 1'b0);
    pin("fixed_addr2", AWADDROUT, exp_awaddrout, 32'hABAB);
    do_beat(32'h33, 1'b1);
    pin("fixed_addr3", AWADDROUT, exp_awaddrout, 32'hABAB);
    pin("fixed_data", WDATAOUT, exp_wdataout, 32'h33);
    pin("fixed_bvalid", BVALID, exp_bvalid, 1);
    pin("fixed_bresp", BRESP, exp_bresp, 2'b00);
    do_b();

    // INCR burst, BREADY already high so BVALID lasts one cycle
    BREADY = 1'b1;
    do_aw(32'h1002, 3'd2, 2'b01);
    do_beat(32'h44, 1'b0);
    pin("incr_addr1", AWADDROUT, exp_awaddrout, 32'h1002);
    do_beat(32'h55, 1'b0);
    pin("incr_addr2", AWADDROUT, exp_awaddrout, 32'h1004);
    do_beat(32'h66, 1'b1);
    pin("incr_addr3", AWADDROUT, exp_awaddrout, 32'h1008);
    pin("incr_bvalid", BVALID, exp_bvalid, 1);
    pin("incr_bresp", BRESP, exp_bresp, 2'b00);
    step();
    pin("incr_bvalid_one_cycle", BVALID, exp_bvalid, 0);
    pin("incr_awready_back", AWREADY, exp_awready, 1);
    BREADY = 1'b0;

    // Error: reserved burst type
    do_aw(32'h2000, 3'd2, 2'b11);
    do_beat(32'hAA, 1'b0);
    do_beat(32'hBB, 1'b1);
    pin("err_burst_data", WDATAOUT, exp_wdataout, 32'h66);
    pin("err_burst_addr", AWADDROUT, exp_awaddrout, 32'h2000);
    pin("err_burst_bresp", BRESP, exp_bresp, 2'b10);
    do_b();

    // Error: beat size wider than bus
    do_aw(32'h3000, 3'd3, 2'b01);
    do_beat(32'hCC, 1'b0);
    do_beat(32'hDD, 1'b1);
    pin("err_size_data", WDATAOUT, exp_wdataout, 32'h66);
    pin("err_size_bresp", BRESP, exp_bresp, 2'b10);
    do_b();
    pin("after_err_bresp", BRESP, exp_bresp, 2'b00);

    // Backpressure on B with stray AW/W activity
    do_aw(32'h4000, 3'd2, 2'b00);
    do_beat(32'h99, 1'b1);
    for (int i = 0; i < 5; i++) begin
      WVALID  = 1'b1;
      WDATA   = 32'hEE;
      AWVALID = 1'b1;
      AWADDR  = 32'h5555;
      step();
      pin("bp_bvalid", BVALID, exp_bvalid, 1);
      pin("bp_awready", AWREADY, exp_awready, 0);
    end
    WVALID  = 1'b0;
    AWVALID = 1'b0;
    pin("bp_wdata", WDATAOUT, exp_wdataout, 32'h99);
    pin("bp_bresp", BRESP, exp_bresp, 2'b00);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    pin("bp_release_bvalid", BVALID, exp_bvalid, 0);
    pin("bp_release_awready", AWREADY, exp_awready, 1);

    // Reset mid-burst
    do_aw(32'h5000, 3'd2, 2'b01);
    do_beat(32'h77, 1'b0);
    #1;
    ARESETn = 1'b1;
    #1;
    pin("midrst_wready", WREADY, exp_wready, 0);
    pin("midrst_awaddrout", AWADDROUT, exp_awaddrout, 0);
    pin("midrst_wdataout", WDATAOUT, exp_wdataout, 0);
    pin("midrst_bvalid", BVALID, exp_bvalid, 0);
    step();
    step();
    ARESETn = 1'b0;
    do_aw(32'h6000, 3'd2, 2'b01);
    do_beat(32'h1, 1'b0);
    do_beat(32'h2, 1'b1);
    pin("post_rst_addr", AWADDROUT, exp_awaddrout, 32'h6004);
    pin("post_rst_data", WDATAOUT, exp_wdataout, 32'h2);
    pin("post_rst_bresp", BRESP, exp_bresp, 2'b00);
    do_b();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
